// File: rtl/lin_ahb_sram_pkg.sv
// Shared encodings for the AHB-to-SRAM slave: transfer type, response, size and FSM states.
package lin_ahb_sram_pkg;

    localparam logic [1:0] HTRANS_IDLE   = 2'b00;
    localparam logic [1:0] HTRANS_BUSY   = 2'b01;
    localparam logic [1:0] HTRANS_NONSEQ = 2'b10;
    localparam logic [1:0] HTRANS_SEQ    = 2'b11;

    localparam logic [1:0] HRESP_OKAY  = 2'b00;
    localparam logic [1:0] HRESP_ERROR = 2'b01;

    localparam logic [2:0] HSIZE_BYTE = 3'b000;
    localparam logic [2:0] HSIZE_HALF = 3'b001;
    localparam logic [2:0] HSIZE_WORD = 3'b010;

    localparam logic [3:0] BE_ALL = 4'b1111;

    typedef enum logic [2:0] {
        ST_IDLE    = 3'd0,
        ST_WR      = 3'd1,
        ST_RD      = 3'd2,
        ST_RD_WAIT = 3'd3,
        ST_ERR1    = 3'd4,
        ST_ERR2    = 3'd5
    } state_e;

endpackage

// File: rtl/lin_ahb_sram_slave_if.sv
// AHB-Lite slave-side bus bundle; hready is the bus-level ready returned by the interconnect.
interface lin_ahb_sram_slave_if #(
    parameter int ADDR_WIDTH = 16,
    parameter int DATA_WIDTH = 32
);
    logic                  hsel;
    logic [ADDR_WIDTH-1:0] haddr;
    logic [1:0]            htrans;
    logic [2:0]            hsize;
    logic [2:0]            hburst;
    logic                  hwrite;
    logic                  hready;
    logic [DATA_WIDTH-1:0] hwdata;
    logic                  hreadyout;
    logic [1:0]            hresp;
    logic [DATA_WIDTH-1:0] hrdata;

    modport master (
        output hsel, haddr, htrans, hsize, hburst, hwrite, hready, hwdata,
        input  hreadyout, hresp, hrdata
    );

    modport slave (
        input  hsel, haddr, htrans, hsize, hburst, hwrite, hready, hwdata,
        output hreadyout, hresp, hrdata
    );
endinterface

// File: rtl/lin_ahb_sram_be_gen.sv
// Byte-lane decode of address LSBs and transfer size, flagging oversize or misaligned transfers.
// Purely combinational, no backpressure.
module lin_ahb_sram_be_gen
    import lin_ahb_sram_pkg::*;
(
    input  logic [1:0] addr_lo,
    input  logic [2:0] hsize,
    output logic [3:0] be,
    output logic       err
);

    always_comb begin
        be  = 4'b0000;
        err = 1'b0;
        case (hsize)
            HSIZE_BYTE: be = 4'b0001 << addr_lo;
            HSIZE_HALF: begin
                be  = addr_lo[1] ? 4'b1100 : 4'b0011;
                err = addr_lo[0];
            end
            HSIZE_WORD: begin
                be  = BE_ALL;
                err = |addr_lo;
            end
            default: err = 1'b1;
        endcase
    end

endmodule

// File: rtl/lin_ahb_sram_slave.sv
// AHB-Lite slave bridging onto a single-port synchronous SRAM with one-cycle read latency.
// Zero-wait writes and reads; one wait state for a read right after a write, two-cycle ERROR.
module lin_ahb_sram_slave
    import lin_ahb_sram_pkg::*;
#(
    parameter int ADDR_WIDTH = 16,
    parameter int DATA_WIDTH = 32
) (
    input  logic                  hclk,
    input  logic                  hresetn,
    lin_ahb_sram_slave_if.slave   ahb,
    output logic                  sram_cs,
    output logic                  sram_we,
    output logic [3:0]            sram_be,
    output logic [ADDR_WIDTH-3:0] sram_addr,
    output logic [DATA_WIDTH-1:0] sram_wdata,
    input  logic [DATA_WIDTH-1:0] sram_rdata
);

    state_e                state_q;
    state_e                state_nxt;
    logic [ADDR_WIDTH-3:0] addr_q;
    logic [3:0]            be_q;
    logic [2:0]            size_q;

    logic [3:0]            be_dec;
    logic                  size_err;
    logic                  evaluating;
    logic                  accept;
    logic                  acc_wr;
    logic                  acc_rd;
    logic                  acc_err;
    logic                  rd_now;

    lin_ahb_sram_be_gen u_be_gen (
        .addr_lo (ahb.haddr[1:0]),
        .hsize   (ahb.hsize),
        .be      (be_dec),
        .err     (size_err)
    );

    // RD_WAIT and ERR1 stall the bus, so no new address phase can be taken there.
    assign evaluating = (state_q != ST_RD_WAIT) && (state_q != ST_ERR1);
    assign accept     = hresetn & evaluating & ahb.hsel & ahb.hready & ahb.htrans[1];
    assign acc_err    = accept & size_err;
    assign acc_wr     = accept & ~size_err & ahb.hwrite;
    assign acc_rd     = accept & ~size_err & ~ahb.hwrite;
    // The RAM port belongs to the write data phase in WR, so a read there is deferred.
    assign rd_now     = acc_rd & (state_q != ST_WR);

    always_ff @(posedge hclk or negedge hresetn) begin
        if (!hresetn) begin
            state_q <= ST_IDLE;
        end else begin
            state_q <= state_nxt;
        end
    end

    always_comb begin
        state_nxt = state_q;
        case (state_q)
            ST_RD_WAIT: state_nxt = ST_RD;
            ST_ERR1:    state_nxt = ST_ERR2;
            default: begin
                if (ahb.hready) begin
                    if (acc_err) begin
                        state_nxt = ST_ERR1;
                    end else if (acc_wr) begin
                        state_nxt = ST_WR;
                    end else if (acc_rd) begin
                        state_nxt = (state_q == ST_WR) ? ST_RD_WAIT : ST_RD;
                    end else begin
                        state_nxt = ST_IDLE;
                    end
                end
            end
        endcase
    end

    always_ff @(posedge hclk or negedge hresetn) begin
        if (!hresetn) begin
            addr_q <= '0;
            be_q   <= 4'b0000;
            size_q <= 3'b000;
        end else if (acc_wr || acc_rd) begin
            addr_q <= ahb.haddr[ADDR_WIDTH-1:2];
            be_q   <= acc_wr ? be_dec : BE_ALL;
            size_q <= ahb.hsize;
        end
    end

    always_comb begin
        ahb.hreadyout = 1'b1;
        ahb.hresp     = HRESP_OKAY;
        ahb.hrdata    = '0;
        sram_cs       = 1'b0;
        sram_we       = 1'b0;
        sram_be       = 4'b0000;
        sram_addr     = '0;
        sram_wdata    = '0;
        case (state_q)
            ST_WR: begin
                sram_cs    = 1'b1;
                sram_we    = 1'b1;
                sram_be    = be_q;
                sram_addr  = addr_q;
                sram_wdata = ahb.hwdata;
            end
            ST_RD: begin
                ahb.hrdata = sram_rdata;
            end
            ST_RD_WAIT: begin
                ahb.hreadyout = 1'b0;
                sram_cs       = 1'b1;
                sram_be       = BE_ALL;
                sram_addr     = addr_q;
            end
            ST_ERR1: begin
                ahb.hreadyout = 1'b0;
                ahb.hresp     = HRESP_ERROR;
            end
            ST_ERR2: begin
                ahb.hresp = HRESP_ERROR;
            end
            default: ;
        endcase
        if (rd_now) begin
            sram_cs   = 1'b1;
            sram_we   = 1'b0;
            sram_be   = BE_ALL;
            sram_addr = ahb.haddr[ADDR_WIDTH-1:2];
        end
    end

    // hburst is ignored; htrans[0] only separates NONSEQ from SEQ, which are treated alike.
    logic unused_bits;
    assign unused_bits = ^{1'b0, ahb.hburst, ahb.htrans[0], size_q};

endmodule

// File: tb/tb_lin_ahb_sram_slave.sv
// Directed bench for lin_ahb_sram_slave with a transfer-level reference model and SRAM model.
module tb_lin_ahb_sram_slave;
    import lin_ahb_sram_pkg::*;

    localparam int AW    = 16;
    localparam int WORDS = 1 << (AW - 2);

    typedef enum int {K_IDLE, K_WR, K_RD, K_WAIT, K_E1, K_E2} kind_e;
    typedef struct {
        kind_e      kind;
        int         word;
        logic [3:0] be;
    } ent_t;

    logic          hclk = 1'b0;
    logic          hresetn;
    logic          sram_cs;
    logic          sram_we;
    logic [3:0]    sram_be;
    logic [AW-3:0] sram_addr;
    logic [31:0]   sram_wdata;
    logic [31:0]   sram_rdata;

    lin_ahb_sram_slave_if #(.ADDR_WIDTH(AW), .DATA_WIDTH(32)) bus ();
    assign bus.hready = bus.hreadyout;

    lin_ahb_sram_slave #(.ADDR_WIDTH(AW), .DATA_WIDTH(32)) dut (
        .hclk       (hclk),
        .hresetn    (hresetn),
        .ahb        (bus.slave),
        .sram_cs    (sram_cs),
        .sram_we    (sram_we),
        .sram_be    (sram_be),
        .sram_addr  (sram_addr),
        .sram_wdata (sram_wdata),
        .sram_rdata (sram_rdata)
    );

    always #5 hclk = ~hclk;

    int          n_checks  = 0;
    int          n_pass    = 0;
    int          cyc       = 0;
    int          obs_waits = 0;
    int          obs_cs    = 0;
    int          obs_err   = 0;
    int          obs_rds   = 0;
    logic [31:0] obs_rdata = 32'h0;
    logic [3:0]  obs_wr_be = 4'h0;

    logic [31:0] mem    [WORDS];
    logic [31:0] shadow [WORDS];
    ent_t        exp_q  [$];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
    endtask

    function automatic bit size_bad(input int addr, input int sz);
        if (sz > 2) return 1'b1;
        return (addr % (1 << sz)) != 0;
    endfunction

    function automatic logic [3:0] lanes(input int addr, input int sz);
        logic [3:0] m;
        int first;
        m = 4'h0;
        first = addr % 4;
        for (int b = 0; b < 4; b++)
            if (b >= first && b < first + (1 << sz)) m[b] = 1'b1;
        return m;
    endfunction

    // Synchronous SRAM: read data appears the cycle after the strobe.
    always @(posedge hclk) begin
        if (sram_cs) begin
            if (sram_we) begin
                for (int b = 0; b < 4; b++)
                    if (sram_be[b]) mem[sram_addr][8*b +: 8] <= sram_wdata[8*b +: 8];
            end else begin
                sram_rdata <= mem[sram_addr];
            end
        end
        cyc <= cyc + 1;
    end

    // Every cycle: pop this cycle's data-phase expectation (idle when none), then enqueue
    // the data phase of any address phase the model says is accepted at the coming edge.
    always @(negedge hclk) begin : cmp
        ent_t        cur;
        logic        e_rdy;
        logic        e_cs;
        logic        e_we;
        logic [1:0]  e_resp;
        logic [31:0] e_rdata;
        logic [3:0]  e_be;
        int          e_addr;
        int          a;
        int          sz;
        if (!hresetn) begin
            exp_q.delete();
            check("rst_hreadyout", 32'(bus.hreadyout), 32'd1);
            check("rst_hresp", 32'(bus.hresp), 32'd0);
            check("rst_hrdata", bus.hrdata, 32'd0);
            check("rst_sram_cs", 32'(sram_cs), 32'd0);
            check("rst_sram_be", 32'(sram_be), 32'd0);
        end else begin
            if (exp_q.size() > 0) cur = exp_q.pop_front();
            else cur = '{K_IDLE, 0, 4'h0};
            e_rdy   = !(cur.kind inside {K_WAIT, K_E1});
            e_resp  = (cur.kind inside {K_E1, K_E2}) ? 2'b01 : 2'b00;
            e_rdata = (cur.kind == K_RD) ? shadow[cur.word] : 32'h0;
            e_cs    = cur.kind inside {K_WR, K_WAIT};
            e_we    = (cur.kind == K_WR);
            e_be    = e_we ? cur.be : 4'hF;
            e_addr  = cur.word;
            if (e_rdy && bus.hsel && bus.htrans[1]) begin
                a  = int'(bus.haddr);
                sz = int'(bus.hsize);
                if (size_bad(a, sz)) begin
                    exp_q.push_back('{K_E1, 0, 4'h0});
                    exp_q.push_back('{K_E2, 0, 4'h0});
                end else if (bus.hwrite) begin
                    exp_q.push_back('{K_WR, a / 4, lanes(a, sz)});
                end else if (cur.kind == K_WR) begin
                    exp_q.push_back('{K_WAIT, a / 4, 4'hF});
                    exp_q.push_back('{K_RD, a / 4, 4'hF});
                end else begin
                    exp_q.push_back('{K_RD, a / 4, 4'hF});
                    e_cs   = 1'b1;
                    e_we   = 1'b0;
                    e_be   = 4'hF;
                    e_addr = a / 4;
                end
            end
            check("hreadyout", 32'(bus.hreadyout), 32'(e_rdy));
            check("hresp", 32'(bus.hresp), 32'(e_resp));
            check("hrdata", bus.hrdata, e_rdata);
            check("sram_cs", 32'(sram_cs), 32'(e_cs));
            if (e_cs) begin
                check("sram_we", 32'(sram_we), 32'(e_we));
                check("sram_be", 32'(sram_be), 32'(e_be));
                check("sram_addr", 32'(sram_addr), 32'(e_addr));
            end
            if (e_we) check("sram_wdata", sram_wdata, bus.hwdata);
            if (cur.kind == K_WR)
                for (int b = 0; b < 4; b++)
                    if (cur.be[b]) shadow[cur.word][8*b +: 8] = bus.hwdata[8*b +: 8];
            if (!bus.hreadyout) obs_waits++;
            if (sram_cs) obs_cs++;
            if (bus.hresp == 2'b01) obs_err++;
            if (sram_cs && sram_we) obs_wr_be = sram_be;
            if (cur.kind == K_RD) begin
                obs_rdata = bus.hrdata;
                obs_rds++;
            end
        end
    end

    task automatic xfer(input logic sel, input logic [1:0] trans, input logic wr,
                        input logic [2:0] size, input logic [15:0] addr, input logic [31:0] wdata);
        int n;
        n = 0;
        bus.hsel   = sel;
        bus.htrans = trans;
        bus.hwrite = wr;
        bus.hsize  = size;
        bus.haddr  = addr;
        @(negedge hclk);
        while (!bus.hready && n < 20) begin
            n++;
            @(negedge hclk);
        end
        if (!bus.hready) begin
            n_checks++;
            $display("FAIL xfer_timeout: hready still %b after %0d cycles, required 1", bus.hready, n);
        end
        @(posedge hclk);
        #1;
        bus.hwdata = wdata;
    endtask

    task automatic wr(input logic [15:0] addr, input logic [2:0] size, input logic [31:0] d);
        xfer(1'b1, HTRANS_NONSEQ, 1'b1, size, addr, d);
    endtask

    task automatic rd(input logic [15:0] addr, input logic [2:0] size);
        xfer(1'b1, HTRANS_NONSEQ, 1'b0, size, addr, 32'h0);
    endtask

    task automatic idle();
        xfer(1'b0, HTRANS_IDLE, 1'b0, HSIZE_WORD, 16'h0, 32'h0);
    endtask

    initial begin
        int s_w, s_cs, s_err, s_r, c0;
        hresetn    = 1'b0;
        bus.hsel   = 1'b0;
        bus.htrans = HTRANS_IDLE;
        bus.hwrite = 1'b0;
        bus.hsize  = HSIZE_WORD;
        bus.hburst = 3'b000;
        bus.haddr  = 16'h0;
        bus.hwdata = 32'h0;
        repeat (2) @(posedge hclk);
        #1;
        check("reset_hreadyout", 32'(bus.hreadyout), 32'd1);
        check("reset_sram_cs", 32'(sram_cs), 32'd0);
        hresetn = 1'b1;
        @(posedge hclk);
        #1;

        // Word write then read of the same word: one wait state.
        s_w = obs_waits;
        wr(16'h0010, HSIZE_WORD, 32'hDEAD_BEEF);
        rd(16'h0010, HSIZE_WORD);
        idle();
        check("t39_wr_be", 32'(obs_wr_be), 32'hF);
        check("t39_waits", 32'(obs_waits - s_w), 32'd1);
        check("t39_rdata", obs_rdata, 32'hDEAD_BEEF);
        check("t39_model_word", shadow[4], 32'hDEAD_BEEF);

        // Byte write to lane 3, idle, then zero-wait word read.
        s_w = obs_waits;
        wr(16'h0013, HSIZE_BYTE, 32'hA500_0000);
        idle();
        rd(16'h0010, HSIZE_WORD);
        idle();
        check("t40_wr_be", 32'(obs_wr_be), 32'h8);
        check("t40_waits", 32'(obs_waits - s_w), 32'd0);
        check("t40_rdata", obs_rdata, 32'hA5AD_BEEF);

        // Misaligned half-word and oversize word, back to back.
        s_w = obs_waits; s_cs = obs_cs; s_err = obs_err;
        xfer(1'b1, HTRANS_NONSEQ, 1'b0, HSIZE_HALF, 16'h0021, 32'h0);
        xfer(1'b1, HTRANS_NONSEQ, 1'b1, 3'b011, 16'h0024, 32'h1111_2222);
        idle();
        check("t41_no_cs", 32'(obs_cs - s_cs), 32'd0);
        check("t41_waits", 32'(obs_waits - s_w), 32'd2);
        check("t41_err_cycles", 32'(obs_err - s_err), 32'd4);

        // Write->write, half-word merge, read after write.
        wr(16'h0020, HSIZE_WORD, 32'hCAFE_F00D);
        wr(16'h0022, HSIZE_HALF, 32'h1234_0000);
        check("t_half_be", 32'(obs_wr_be), 32'hF);
        rd(16'h0020, HSIZE_WORD);
        idle();
        check("t_half_be2", 32'(obs_wr_be), 32'hC);
        check("t_half_rdata", obs_rdata, 32'h1234_F00D);

        // Preload then four back-to-back reads.
        wr(16'h0000, HSIZE_WORD, 32'h1111_1111);
        wr(16'h0004, HSIZE_WORD, 32'h2222_2222);
        wr(16'h0008, HSIZE_WORD, 32'h3333_3333);
        wr(16'h000C, HSIZE_WORD, 32'h4444_4444);
        idle();
        s_w = obs_waits; s_r = obs_rds; c0 = cyc;
        bus.hburst = 3'b011;
        xfer(1'b1, HTRANS_NONSEQ, 1'b0, HSIZE_WORD, 16'h0000, 32'h0);
        xfer(1'b1, HTRANS_SEQ,    1'b0, HSIZE_WORD, 16'h0004, 32'h0);
        xfer(1'b1, HTRANS_SEQ,    1'b0, HSIZE_WORD, 16'h0008, 32'h0);
        xfer(1'b1, HTRANS_SEQ,    1'b0, HSIZE_WORD, 16'h000C, 32'h0);
        bus.hburst = 3'b000;
        idle();
        check("t42_reads", 32'(obs_rds - s_r), 32'd4);
        check("t42_waits", 32'(obs_waits - s_w), 32'd0);
        check("t42_cycles", 32'(cyc - c0), 32'd5);
        check("t42_last_rdata", obs_rdata, 32'h4444_4444);

        // Reset pulsed while the deferred read is waiting.
        wr(16'h0040, HSIZE_WORD, 32'h5A5A_A5A5);
        rd(16'h0040, HSIZE_WORD);
        bus.hsel   = 1'b0;
        bus.htrans = HTRANS_IDLE;
        check("t43_in_wait", 32'(bus.hreadyout), 32'd0);
        #1;
        hresetn = 1'b0;
        #1;
        check("t43_rst_hreadyout", 32'(bus.hreadyout), 32'd1);
        check("t43_rst_cs", 32'(sram_cs), 32'd0);
        @(negedge hclk);
        #2;
        hresetn = 1'b1;
        @(posedge hclk);
        #1;
        s_w = obs_waits;
        rd(16'h0040, HSIZE_WORD);
        idle();
        check("t43_rdata", obs_rdata, 32'h5A5A_A5A5);
        check("t43_waits", 32'(obs_waits - s_w), 32'd0);

        // Selected BUSY / IDLE and unselected NONSEQ: no RAM traffic.
        s_w = obs_waits; s_cs = obs_cs; s_err = obs_err;
        xfer(1'b1, HTRANS_BUSY,   1'b0, HSIZE_WORD, 16'h0010, 32'h0);
        xfer(1'b1, HTRANS_IDLE,   1'b1, HSIZE_WORD, 16'h0010, 32'h0);
        xfer(1'b0, HTRANS_NONSEQ, 1'b0, HSIZE_WORD, 16'h0010, 32'h0);
        xfer(1'b0, HTRANS_NONSEQ, 1'b1, HSIZE_WORD, 16'h0010, 32'h0);
        idle();
        check("t44_no_cs", 32'(obs_cs - s_cs), 32'd0);
        check("t44_waits", 32'(obs_waits - s_w), 32'd0);
        check("t44_no_err", 32'(obs_err - s_err), 32'd0);
        check("t44_model_word", shadow[4], 32'hA5AD_BEEF);

        repeat (2) @(posedge hclk);
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

    initial begin
        #100000;
        $display("FAIL watchdog: simulation still running at %0t, required to finish earlier", $time);
        $fatal(1, "watchdog expired");
    end

endmodule

// File: doc/lin_ahb_sram_slave.md
LIN_AHB_SRAM_SLAVE -- requirements
Module: lin_ahb_sram_slave

Interface
REQ-001 SHALL have parameter ADDR_WIDTH, default 16: byte-address width of the RAM window (64 KiB).
REQ-002 SHALL have parameter DATA_WIDTH, default 32: fixed bus and RAM word width; no other value is supported.
REQ-003 SHALL have one clock and an asynchronous, active-low reset: hclk in 1 = clock; hresetn in 1 = reset.
REQ-004 Port hsel, in, 1: slave select.
REQ-005 Port haddr, in, ADDR_WIDTH: byte address.
REQ-006 Port htrans, in, 2: IDLE=00, BUSY=01, NONSEQ=10, SEQ=11.
REQ-007 Port hsize, in, 3: transfer size.
REQ-008 Port hburst, in, 3: burst type; ignored, and bursts are handled as individual transfers.
REQ-009 Port hwrite, in, 1: 1 = write.
REQ-010 Port hready, in, 1: bus-level ready.
REQ-011 Port hwdata, in, 32: write data, valid in the data phase.
REQ-012 Port hreadyout, out, 1: slave ready.
REQ-013 Port hresp, out, 2: OKAY=00, ERROR=01.
REQ-014 Port hrdata, out, 32: read data.
REQ-015 Port sram_cs, out, 1: RAM access strobe.
REQ-016 Port sram_we, out, 1: RAM write enable.
REQ-017 Port sram_be, out, 4: RAM byte enables.
REQ-018 Port sram_addr, out, ADDR_WIDTH-2: RAM word address.
REQ-019 Port sram_wdata, out, 32: RAM write data.
REQ-020 Port sram_rdata, in, 32: RAM read data, valid exactly one cycle after a read strobe.

Function
REQ-021 Transfer accepted when hsel & hready & htrans[1]=1; IDLE/BUSY transfers, or transfers with hsel=0, get a zero-wait OKAY and cause no RAM access.
REQ-022 Accepted transfer SHALL be an error when hsize>010, or half-word with haddr[0]=1, or word with haddr[1:0]!=00.
REQ-023 Byte enables: byte = 0001<<haddr[1:0]; half = 0011<<(2*haddr[1]); word = 1111; reads SHALL drive sram_be=1111.
REQ-024 FSM states: IDLE, WR, RD, RD_WAIT, ERR1, ERR2; next state is evaluated only in cycles where hready=1, except RD_WAIT->RD and ERR1->ERR2, which are unconditional.
REQ-025 Accepted valid write -> WR. Address, be and size SHALL be registered. In the WR cycle: sram_cs=1, sram_we=1, sram_wdata=hwdata, hreadyout=1.
REQ-026 Accepted valid read while not in WR: sram_cs=1, sram_we=0, sram_addr=haddr[ADDR_WIDTH-1:2] combinationally in the address-phase cycle, then -> RD. In RD: hrdata=sram_rdata, hreadyout=1 (zero wait).
REQ-027 Accepted valid read while in WR (RAM port busy): store address and go -> RD_WAIT. In RD_WAIT: issue the read from the stored address, hreadyout=0; then -> RD (exactly one wait state).
REQ-028 Accepted error transfer -> ERR1: hreadyout=0, hresp=01, no RAM access; -> ERR2: hreadyout=1, hresp=01. The transfer accepted in ERR2 SHALL be processed normally.
REQ-029 No accepted transfer -> IDLE, hreadyout=1, hresp=00.
REQ-030 hrdata SHALL be 0 in all states except RD; hresp SHALL be 00 in all states except ERR1/ERR2.
REQ-031 sram_cs SHALL never assert twice in one cycle; write has priority, and the read is deferred per REQ-027.
REQ-032 Address wrap-around: the address SHALL be truncated to ADDR_WIDTH bits, with no error for out-of-window addresses.
REQ-033 Back-to-back write->write and read->read transfers SHALL sustain one transfer per cycle.

Reset
REQ-034 On hresetn=0, the FSM SHALL go to IDLE immediately and asynchronously: hreadyout=1, hresp=00, hrdata=0, sram_cs=0, sram_we=0, sram_be=0, all registered address/size cleared.
REQ-035 Reset mid-transfer SHALL abort the transfer without completing it; the first accepted transfer after release behaves as from IDLE.

Structure
REQ-036 Shared package lin_ahb_sram_pkg SHALL hold the htrans, hresp and hsize encodings and the FSM state enum.
REQ-037 Sub-module lin_ahb_sram_be_gen SHALL be a combinational sub-module: haddr[1:0] + hsize -> sram_be, misaligned/oversize error flag.
REQ-038 Top-level: FSM plus address/control pipeline registers; target 150-300 RTL lines.

Verification
REQ-039 Write word 0x0000_0010 = 0xDEAD_BEEF, then read 0x10 -> sram_be=1111 on the write, exactly one wait state on the read (RD_WAIT), hrdata=0xDEAD_BEEF, hresp=00.
REQ-040 Byte write 0xA5 at 0x13, then idle, then word read at 0x10 -> sram_be=1000 on the write, zero-wait read, hrdata[31:24]=0xA5.
REQ-041 Half-word at 0x21, and word with hsize=011 -> two-cycle ERROR each (hreadyout 0 then 1), sram_cs never asserted.
REQ-042 Four back-to-back reads 0x0, 0x4, 0x8, 0xC -> four data phases in four consecutive cycles, no waits.
REQ-043 hresetn pulsed low during RD_WAIT -> hreadyout=1, sram_cs=0 the same cycle; next read after release returns correct data.
REQ-044 hsel=1 with htrans=BUSY or IDLE -> hreadyout=1, hresp=00, no sram_cs.
